// File: rtl/pipe_adder.sv
// Carry-chunked pipelined adder/subtractor with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   Sum
);
    localparam int STAGES = WIDTH / CHUNK;

    logic [WIDTH-1:0] w_a  [STAGES];
    logic [WIDTH-1:0] w_b  [STAGES];
    logic [WIDTH-1:0] w_ps [STAGES];
    logic             w_ci [STAGES];
    logic             w_vi [STAGES];
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic             w_vo;

    assign in_ready  = ~(out_valid & ~out_ready);
    assign out_valid = w_vo;
    assign Sum       = {w_co, w_sum};

    // Subtract is A + ~B + ~c, so invert B and the carry-in up front
    assign w_a[0]  = A;
    assign w_b[0]  = B ^ {WIDTH{sub}};
    assign w_ci[0] = c ^ sub;
    assign w_ps[0] = '0;
    assign w_vi[0] = in_valid;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   w_add;
        logic [WIDTH-1:0] r_s;
        logic             r_cy;
        logic             r_v;

        assign w_add = {1'b0, w_a[k][CHUNK-1:0]}
                     + {1'b0, w_b[k][CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, w_ci[k]};

        // Operands shift down and sum slices shift in from the top,
        // so the active slice is always bits [CHUNK-1:0].
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s  <= '0;
                r_cy <= 1'b0;
                r_v  <= 1'b0;
            end else if (in_ready) begin
                r_s  <= (w_ps[k] >> CHUNK)
                      | {w_add[CHUNK-1:0], {(WIDTH-CHUNK){1'b0}}};
                r_cy <= w_add[CHUNK];
                r_v  <= w_vi[k];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (in_ready) begin
                    r_a <= w_a[k] >> CHUNK;
                    r_b <= w_b[k] >> CHUNK;
                end
            end

            assign w_a[k+1]  = r_a;
            assign w_b[k+1]  = r_b;
            assign w_ps[k+1] = r_s;
            assign w_ci[k+1] = r_cy;
            assign w_vi[k+1] = r_v;
        end else begin : g_tail
            assign w_sum = r_s;
            assign w_co  = r_cy;
            assign w_vo  = r_v;
`ifdef PIPE_ADDER_OVF_EN
            logic w_ovf_n;
            logic r_ovf;

            // Last stage sees the operand sign bits, so overflow is decided here
            assign w_ovf_n = (w_a[k][CHUNK-1] == w_b[k][CHUNK-1])
                           & (w_add[CHUNK-1] != w_a[k][CHUNK-1]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (in_ready) begin
                    r_ovf <= w_ovf_n;
                end
            end

            assign ovf = r_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=16, CHUNK=4).
// Covers latency, subtract, stall/hold, async reset, bubbles and ovf.
module tb_pipe_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        c;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] Sum;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf;
`endif

    int n_chk = 0;
    int n_err = 0;

    pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c         (c),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .Sum       (Sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_sum(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic        ci,
                                            input logic        s);
        logic [16:0] r;
        if (s)
            r = {1'b0, a} + {1'b0, ~b} + {16'd0, ~ci};
        else
            r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        return r;
    endfunction

    // Called just after a negedge; result must appear at the 4th negedge
    task automatic send1(input string tag,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s,
                         input logic [16:0] exp, input logic eovf);
        A = a; B = b; c = ci; sub = s;
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 4) begin
                check({tag, "_early"}, out_valid, 1'b0);
            end else begin
                check({tag, "_vld"}, out_valid, 1'b1);
                check({tag, "_sum"}, Sum, exp);
`ifdef PIPE_ADDER_OVF_EN
                check({tag, "_ovf"}, ovf, eovf);
`else
                if (eovf === 1'bx) check({tag, "_x"}, 0, 1);
`endif
            end
        end
        @(negedge clk);
    endtask

    logic [16:0] q[$];
    logic [16:0] held;
    logic [15:0] pa, pb;
    logic        pc, ps;
    logic        pat[14];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; c = 1'b0; sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_vld", out_valid, 1'b0);
        check("rst_sum", Sum, 17'h0);
        check("rst_rdy", in_ready, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rdy", in_ready, 1'b1);

        send1("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
        send1("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
        send1("sub2", 16'h0009, 16'h0003, 1'b1, 1'b1, 17'h10005, 1'b0);
        send1("ovf1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
        send1("ovf2", 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
        send1("ovf3", 16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002, 1'b0);
        send1("addc", 16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0);

        // 8 back-to-back with a 3-cycle consumer stall at first out_valid
        begin
            int sent = 0;
            int got = 0;
            int stall_left = 0;
            int stall_seen = 0;
            bit stall_done = 0;
            pa = 16'($urandom); pb = 16'($urandom);
            pc = 1'($urandom); ps = 1'($urandom);
            for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
                if (out_valid && !stall_done) begin
                    stall_left = 3;
                    stall_done = 1;
                end
                out_ready = (stall_left == 0);
                #1;
                if (stall_left > 0) begin
                    check("stall_rdy", in_ready, 1'b0);
                    stall_seen++;
                    if (stall_left == 3) held = Sum;
                    else check("stall_hold", Sum, held);
                    stall_left--;
                end else begin
                    check("run_rdy", in_ready, 1'b1);
                end
                if (out_valid && out_ready) begin
                    if (q.size() > 0) check("ord_sum", Sum, q.pop_front());
                    else check("ord_extra", out_valid, 1'b0);
                    got++;
                end
                if (sent < 8) begin
                    A = pa; B = pb; c = pc; sub = ps;
                    in_valid = 1'b1;
                    if (in_ready) begin
                        q.push_back(ref_sum(pa, pb, pc, ps));
                        sent++;
                        pa = 16'($urandom); pb = 16'($urandom);
                        pc = 1'($urandom); ps = 1'($urandom);
                    end
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            check("ord_cnt", got, 8);
            check("stall_cnt", stall_seen, 3);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Async reset with several transactions in flight
        for (int i = 0; i < 5; i++) begin
            A = 16'(i * 16'h0111); B = 16'h0101; c = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_rst_vld", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_vld", out_valid, 1'b0);
        check("arst_sum", Sum, 17'h0);
        check("arst_rdy", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        send1("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, 1'b0);

        // Bubbles: alternating in_valid appears at out_valid 4 cycles later
        for (int n = 0; n < 14; n++) begin
            pat[n] = (n < 10) ? ((n % 2) == 0) : 1'b0;
            if (n >= 4) check("bubble", out_valid, pat[n-4]);
            else check("bubble_pre", out_valid, 1'b0);
            A = 16'(n); B = 16'h0010; c = 1'b0; sub = 1'b0;
            in_valid = pat[n];
            @(negedge clk);
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
